// File: rtl/wb_bus_master_pkg.sv
// wb_bus_master_pkg: shared state encodings and constants for the Wishbone initiator.
package wb_bus_master_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'b00,
        WB_BUSY = 2'b01,
        WB_HOLD = 2'b10
    } wb_state_e;

    localparam logic        RstEnable      = 1'b0;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    // Load data presented to the CPU when a bus cycle is aborted by timeout.
    localparam logic [31:0] TimeoutErrData = ZeroWord;

endpackage

// File: rtl/wb_bus_master_if.sv
// wb_bus_master_if: classic single-transfer Wishbone signals, named from the initiator side.
interface wb_bus_master_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_bus_master_timeout_ctr.sv
// wb_timeout_ctr: counts BUSY cycles without ack; expired flags the last allowed cycle.
module wb_timeout_ctr
    import wb_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Cycle k of a transfer (k from 0) sees cnt == k, so the TIMEOUT_CYCLES-th cycle is the last.
    assign expired = en && (cnt == LAST);

    // Count waiting cycles; held at zero outside BUSY so each transfer starts fresh.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (wb_rst_i == RstEnable) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_bus_master.sv
// wb_bus_master: CPU load/store port to single-transfer Wishbone initiator.
// Optional bus timeout enabled by defining WB_TIMEOUT_EN.
module wb_bus_master
    import wb_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        bus_err_o,
    wb_bus_master_if.master wb
);

    wb_state_e   state;
    logic        cyc_r;
    logic        we_r;
    logic [31:0] adr_r;
    logic [31:0] dat_r;
    logic [3:0]  sel_r;
    logic [31:0] rd_buf;
    logic        bus_err_r;
    logic        tmo_expired;

    assign wb.wb_cyc_o = cyc_r;
    assign wb.wb_stb_o = cyc_r;
    assign wb.wb_we_o  = we_r;
    assign wb.wb_adr_o = adr_r;
    assign wb.wb_dat_o = dat_r;
    assign wb.wb_sel_o = sel_r;
    assign bus_err_o   = bus_err_r;

`ifdef WB_TIMEOUT_EN
    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clr      (state != WB_BUSY),
        .en       ((state == WB_BUSY) && !wb.wb_ack_i),
        .expired  (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    // Transfer FSM: latch the request, hold the bus until ack/flush/timeout, park in HOLD while frozen.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (wb_rst_i == RstEnable) begin
            state     <= WB_IDLE;
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            adr_r     <= ZeroWord;
            dat_r     <= ZeroWord;
            sel_r     <= 4'h0;
            rd_buf    <= ZeroWord;
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        cyc_r <= 1'b1;
                        we_r  <= cpu_we_i;
                        adr_r <= cpu_addr_i;
                        dat_r <= cpu_data_i;
                        sel_r <= cpu_sel_i;
                        state <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    if (flush_i) begin
                        cyc_r <= 1'b0;
                        we_r  <= 1'b0;
                        state <= WB_IDLE;
                    end else if (wb.wb_ack_i) begin
                        cyc_r <= 1'b0;
                        we_r  <= 1'b0;
                        if (!we_r) rd_buf <= wb.wb_dat_i;
                        state <= stall_i ? WB_HOLD : WB_IDLE;
                    end else if (tmo_expired) begin
                        cyc_r     <= 1'b0;
                        we_r      <= 1'b0;
                        bus_err_r <= 1'b1;
                        state     <= WB_IDLE;
                    end
                end
                WB_HOLD: begin
                    if (!stall_i || flush_i) state <= WB_IDLE;
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    // Pipeline-facing stall and load data; released in the completing cycle so MEM can advance.
    always_comb begin
        stall_o    = 1'b0;
        cpu_data_o = ZeroWord;
        case (state)
            WB_IDLE: stall_o = cpu_ce_i & ~flush_i;
            WB_BUSY: begin
                if (flush_i) begin
                    stall_o = 1'b0;
                end else if (wb.wb_ack_i) begin
                    cpu_data_o = we_r ? ZeroWord : wb.wb_dat_i;
                end else if (tmo_expired) begin
                    cpu_data_o = TimeoutErrData;
                end else begin
                    stall_o = 1'b1;
                end
            end
            WB_HOLD: cpu_data_o = rd_buf;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_master.sv
// tb_wb_bus_master: randomized transactions against a transaction-level expectation model.
// Runs with or without WB_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES = 4).
module tb_wb_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic        stall_i, flush, stall_o, bus_err;

    // Slave register file (written from bus values) and model register file (written from stimulus).
    logic [31:0] smem [16];
    logic [31:0] mmem [16];
    logic [31:0] rdb;

    int n_chk = 0;
    int n_err = 0;

    wb_bus_master_if wb ();

    wb_bus_master #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .cpu_ce_i   (ce),
        .cpu_we_i   (we),
        .cpu_addr_i (addr),
        .cpu_sel_i  (sel),
        .cpu_data_i (wdata),
        .cpu_data_o (rdata),
        .stall_i    (stall_i),
        .flush_i    (flush),
        .stall_o    (stall_o),
        .bus_err_o  (bus_err),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // One CPU access to register k: ack after dly wait cycles, hold cycles of stall_i after ack,
    // flush in BUSY cycle fl_at (-1 for none).
    task automatic txn(input logic w, input int k, input logic [3:0] s, input logic [31:0] d,
                       input int dly, input int hold, input int fl_at);
        logic [31:0] a;
        logic done, flushed, ackd;
        a = 32'h0000_f000 + 32'(k * 4);
        @(negedge clk);
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        stall_i = 1'b0; flush = 1'b0; wb.wb_ack_i = 1'b0;
        #1;
        check("idle_stall", 32'(stall_o), 1);
        check("idle_cyc", 32'(wb.wb_cyc_o), 0);
        done = 1'b0; flushed = 1'b0;
        for (int i = 0; i <= dly && !done; i++) begin
            @(negedge clk);
            addr = $urandom; wdata = $urandom; sel = 4'($urandom);
            ackd    = (i == dly);
            flushed = (i == fl_at);
            wb.wb_ack_i = ackd;
            wb.wb_dat_i = ackd ? smem[k] : $urandom;
            stall_i = ackd ? (hold > 0) : 1'($urandom_range(0, 1));
            flush   = flushed;
            #1;
            check("busy_cyc", 32'(wb.wb_cyc_o), 1);
            check("busy_stb", 32'(wb.wb_stb_o), 1);
            check("busy_we", 32'(wb.wb_we_o), 32'(w));
            check("busy_adr", wb.wb_adr_o, a);
            check("busy_dat", wb.wb_dat_o, d);
            check("busy_sel", 32'(wb.wb_sel_o), 32'(s));
            check("busy_err", 32'(bus_err), 0);
            if (flushed) begin
                check("flush_stall", 32'(stall_o), 0);
                check("flush_data", rdata, 0);
            end else if (ackd) begin
                check("ack_stall", 32'(stall_o), 0);
                check("ack_data", rdata, w ? 32'h0 : mmem[k]);
                if (!w) rdb = mmem[k];
                else begin
                    mmem[k] = merge(mmem[k], d, s);
                    smem[k] = merge(smem[k], wb.wb_dat_o, wb.wb_sel_o);
                end
            end else begin
                check("wait_stall", 32'(stall_o), 1);
                check("wait_data", rdata, 0);
            end
            done = flushed || ackd;
        end
        if (!flushed && hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                wb.wb_ack_i = 1'b0; flush = 1'b0; ce = 1'b1; addr = a;
                stall_i = (h < hold - 1);
                #1;
                check("hold_cyc", 32'(wb.wb_cyc_o), 0);
                check("hold_stall", 32'(stall_o), 0);
                check("hold_data", rdata, rdb);
            end
        end
        @(negedge clk);
        ce = 1'b0; flush = 1'b0; stall_i = 1'b0; wb.wb_ack_i = 1'b0;
        #1;
        check("end_cyc", 32'(wb.wb_cyc_o), 0);
        check("end_stall", 32'(stall_o), 0);
        check("end_data", rdata, 0);
    endtask

    // Slave that never acks: timeout abort when enabled, indefinite wait otherwise.
    task automatic no_ack_test();
        int n;
`ifdef WB_TIMEOUT_EN
        n = 4;
`else
        n = 20;
`endif
        @(negedge clk);
        ce = 1'b1; we = 1'b0; addr = 32'h0000_f004; sel = 4'hF; wb.wb_ack_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wb.wb_ack_i = 1'b0;
            #1;
            check("noack_cyc", 32'(wb.wb_cyc_o), 1);
            check("noack_err", 32'(bus_err), 0);
`ifdef WB_TIMEOUT_EN
            check("noack_stall", 32'(stall_o), (i == n - 1) ? 0 : 1);
`else
            check("noack_stall", 32'(stall_o), 1);
`endif
            check("noack_data", rdata, 0);
        end
`ifdef WB_TIMEOUT_EN
        @(negedge clk);
        ce = 1'b0;
        #1;
        check("tmo_cyc", 32'(wb.wb_cyc_o), 0);
        check("tmo_err", 32'(bus_err), 1);
        check("tmo_stall", 32'(stall_o), 0);
        check("tmo_data", rdata, 0);
        @(negedge clk);
        #1;
        check("tmo_err_pulse", 32'(bus_err), 0);
        check("tmo_cyc2", 32'(wb.wb_cyc_o), 0);
`else
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("noack_flush_stall", 32'(stall_o), 0);
        @(negedge clk);
        flush = 1'b0; ce = 1'b0;
        #1;
        check("noack_flush_cyc", 32'(wb.wb_cyc_o), 0);
        check("noack_flush_err", 32'(bus_err), 0);
`endif
    endtask

    // Reset asserted between edges must drop the bus at once.
    task automatic async_reset_test();
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h0000_f008; sel = 4'hF; wdata = 32'hDEAD_BEEF;
        wb.wb_ack_i = 1'b0;
        @(negedge clk);
        ce = 1'b0;
        #1;
        check("pre_rst_cyc", 32'(wb.wb_cyc_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cyc", 32'(wb.wb_cyc_o), 0);
        check("arst_stb", 32'(wb.wb_stb_o), 0);
        check("arst_we", 32'(wb.wb_we_o), 0);
        check("arst_adr", wb.wb_adr_o, 0);
        check("arst_stall", 32'(stall_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdb = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, k, dly, hold, fl;
        rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        stall_i = 1'b0; flush = 1'b0; wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0;
        rdb = 32'h0;
        for (int i = 0; i < 16; i++) begin
            smem[i] = $urandom;
            mmem[i] = smem[i];
        end
        smem[8] = 32'h0000_003C;  // switches
        mmem[8] = 32'h0000_003C;
        smem[3] = 32'h1234_5678;
        mmem[3] = 32'h1234_5678;

        #13;
        check("rst_cyc", 32'(wb.wb_cyc_o), 0);
        check("rst_stb", 32'(wb.wb_stb_o), 0);
        check("rst_we", 32'(wb.wb_we_o), 0);
        check("rst_adr", wb.wb_adr_o, 0);
        check("rst_dat", wb.wb_dat_o, 0);
        check("rst_sel", 32'(wb.wb_sel_o), 0);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_data", rdata, 0);
        check("rst_err", 32'(bus_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(1'b1, 0, 4'hF, 32'h0000_00A5, 0, 0, -1);  // LED store, same-cycle ack
        txn(1'b0, 0, 4'hF, 32'h0, 0, 0, -1);          // LED readback
        txn(1'b0, 8, 4'hF, 32'h0, 0, 0, -1);          // switches
        txn(1'b1, 2, 4'hF, 32'hCAFE_0102, 3, 0, -1);  // ack delayed 3 cycles
        txn(1'b0, 3, 4'hF, 32'h0, 1, 3, -1);          // ack under stall -> HOLD
        txn(1'b1, 1, 4'hF, 32'h0000_0011, 0, 2, -1);  // store then HOLD keeps last load
        txn(1'b0, 5, 4'hF, 32'h0, 3, 0, 1);           // flush in 2nd BUSY cycle
        txn(1'b0, 5, 4'hF, 32'h0, 0, 0, -1);          // clean restart
        txn(1'b0, 6, 4'hF, 32'h0, 1, 0, 1);           // flush together with ack
        no_ack_test();
        async_reset_test();
        txn(1'b0, 2, 4'hF, 32'h0, 0, 0, -1);          // after reset

        for (int n = 0; n < 60; n++) begin
            w    = $urandom_range(0, 1);
            k    = $urandom_range(0, 15);
            dly  = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            fl   = -1;
            if ($urandom_range(0, 4) == 0) begin
                if (w == 0) fl = $urandom_range(0, dly);
                else if (dly > 0) fl = $urandom_range(0, dly - 1);
            end
            txn(1'(w), k, 4'($urandom_range(1, 15)), $urandom, dly, hold, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
